// File: rtl/reg_scoreboard.sv
// Register-dependency scoreboard: per-register write countdowns and decode stall detection.
// Optional SCOREBOARD_FWD_EN: a source whose count is 1 is forwarded and does not stall.
module reg_scoreboard #(
   parameter int unsigned CNT_W = 3,
   parameter int unsigned NREGS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rd,
   input  logic [CNT_W-1:0] issue_lat,
   input  logic [4:0]       rs1,
   input  logic             rs1_used,
   input  logic [4:0]       rs2,
   input  logic             rs2_used,
   output logic             stall,
   output logic [NREGS-1:0] busy_vec,
   output logic [5:0]       busy_cnt
);

   logic [CNT_W-1:0] cnt     [NREGS];
   logic [CNT_W-1:0] cnt_nxt [NREGS];
   logic [NREGS-1:0] busy_nxt;
   logic [5:0]       pop_nxt;
   logic             load;
   logic [4:0]       src1;
   logic [4:0]       src2;
   logic [CNT_W-1:0] src1_cnt;
   logic [CNT_W-1:0] src2_cnt;
   logic             hit1;
   logic             hit2;

   // Gating on valid keeps X on rd/lat from reaching the count state.
   assign load = issue_valid && (issue_rd != 5'd0) && (issue_lat != '0);

   always_comb begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         cnt_nxt[i] = (cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
         if (load && (issue_rd == 5'(i)))
            cnt_nxt[i] = issue_lat;
         if (flush || (i == 0))
            cnt_nxt[i] = '0;
      end
   end

   always_comb begin
      busy_nxt = '0;
      pop_nxt  = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         busy_nxt[i] = (cnt_nxt[i] != '0);
         pop_nxt     = pop_nxt + 6'(busy_nxt[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++)
            cnt[i] <= '0;
         busy_vec <= '0;
         busy_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++)
            cnt[i] <= cnt_nxt[i];
         busy_vec <= busy_nxt;
         busy_cnt <= pop_nxt;
      end
   end

   // Unused sources are forced to register 0 so X on rs* cannot reach stall.
   assign src1     = rs1_used ? rs1 : 5'd0;
   assign src2     = rs2_used ? rs2 : 5'd0;
   assign src1_cnt = cnt[src1];
   assign src2_cnt = cnt[src2];

`ifdef SCOREBOARD_FWD_EN
   assign hit1 = (src1 != 5'd0) && (src1_cnt > CNT_W'(1));
   assign hit2 = (src2 != 5'd0) && (src2_cnt > CNT_W'(1));
`else
   assign hit1 = (src1 != 5'd0) && (src1_cnt != '0);
   assign hit2 = (src2 != 5'd0) && (src2_cnt != '0);
`endif

   assign stall = hit1 | hit2;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: expected outputs are queued at stimulus time and
// compared as each cycle's outputs are sampled.
module tb_reg_scoreboard;

   localparam int unsigned CNT_W = 3;

`ifdef SCOREBOARD_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic             clock;
   logic             reset;
   logic             flush;
   logic             issue_valid;
   logic [4:0]       issue_rd;
   logic [CNT_W-1:0] issue_lat;
   logic [4:0]       rs1;
   logic             rs1_used;
   logic [4:0]       rs2;
   logic             rs2_used;
   logic             stall;
   logic [31:0]      busy_vec;
   logic [5:0]       busy_cnt;

   typedef struct {
      string       tag;
      logic [31:0] v;
      logic [5:0]  c;
      logic        s;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   reg_scoreboard #(.CNT_W(CNT_W), .NREGS(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_lat   (issue_lat),
      .rs1         (rs1),
      .rs1_used    (rs1_used),
      .rs2         (rs2),
      .rs2_used    (rs2_used),
      .stall       (stall),
      .busy_vec    (busy_vec),
      .busy_cnt    (busy_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic push(input string tag, input logic [31:0] v, input logic [5:0] c, input logic s);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.c   = c;
      e.s   = s;
      q.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      #1;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL queue_empty observed 0 entries required at least 1");
         return;
      end
      e = q.pop_front();
      checks++;
      assert (busy_vec === e.v) else begin
         errors++;
         $error("FAIL %s busy_vec observed %h expected %h", e.tag, busy_vec, e.v);
      end
      checks++;
      assert (busy_cnt === e.c) else begin
         errors++;
         $error("FAIL %s busy_cnt observed %0d expected %0d", e.tag, busy_cnt, e.c);
      end
      checks++;
      assert (stall === e.s) else begin
         errors++;
         $error("FAIL %s stall observed %b expected %b", e.tag, stall, e.s);
      end
   endtask

   // Advance past the next rising edge, drop single-cycle pulses, then sample.
   task automatic step();
      @(posedge clock);
      #1;
      issue_valid = 1'b0;
      flush       = 1'b0;
      compare();
   endtask

   task automatic issue(input logic [4:0] rd, input logic [CNT_W-1:0] lat);
      issue_valid = 1'b1;
      issue_rd    = rd;
      issue_lat   = lat;
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      issue_lat   = 3'd3;
      rs1         = 5'd5;
      rs1_used    = 1'b1;
      rs2         = 5'd0;
      rs2_used    = 1'b0;

      // Reset held two cycles while an issue is presented.
      push("reset_c1", 32'h0, 6'd0, 1'b0);
      @(posedge clock); #1; compare();
      issue(5'd5, 3'd3);
      push("reset_c2", 32'h0, 6'd0, 1'b0);
      @(posedge clock); #1; compare();
      reset       = 1'b0;
      issue_valid = 1'b0;
      push("reset_rel", 32'h0, 6'd0, 1'b0);
      step();

      // Basic countdown on r7 with rs1 dependent.
      rs1 = 5'd7;
      rs1_used = 1'b1;
      issue(5'd7, 3'd3);
      push("r7_c1", 32'h80, 6'd1, 1'b1);
      push("r7_c2", 32'h80, 6'd1, 1'b1);
      push("r7_c3", 32'h80, 6'd1, ~FWD);
      push("r7_free", 32'h0, 6'd0, 1'b0);
      repeat (4) step();

      // r0 and zero-latency issues are ignored.
      rs1 = 5'd0;
      issue(5'd0, 3'd7);
      push("r0_issue", 32'h0, 6'd0, 1'b0);
      step();
      rs1 = 5'd9;
      issue(5'd9, 3'd0);
      push("lat0_issue", 32'h0, 6'd0, 1'b0);
      step();

      // X on inputs whose qualifier is low.
      issue_rd  = 'x;
      issue_lat = 'x;
      rs1       = 'x;
      rs1_used  = 1'b0;
      rs2       = 'x;
      rs2_used  = 1'b0;
      push("x_inputs", 32'h0, 6'd0, 1'b0);
      step();

      // WAW on r4: newer latency replaces the older count.
      rs1 = 5'd4;
      rs1_used = 1'b1;
      rs2 = 5'd0;
      issue(5'd4, 3'd2);
      push("waw_first", 32'h10, 6'd1, 1'b1);
      step();
      issue(5'd4, 3'd5);
      push("waw_c1", 32'h10, 6'd1, 1'b1);
      push("waw_c2", 32'h10, 6'd1, 1'b1);
      push("waw_c3", 32'h10, 6'd1, 1'b1);
      push("waw_c4", 32'h10, 6'd1, 1'b1);
      push("waw_c5", 32'h10, 6'd1, ~FWD);
      push("waw_free", 32'h0, 6'd0, 1'b0);
      repeat (6) step();

      // Popcount tracking, then flush with a competing issue.
      rs1_used = 1'b0;
      issue(5'd3, 3'd7);
      push("pop1", 32'h8, 6'd1, 1'b0);
      step();
      issue(5'd6, 3'd7);
      push("pop2", 32'h48, 6'd2, 1'b0);
      step();
      issue(5'd12, 3'd7);
      push("pop3", 32'h1048, 6'd3, 1'b0);
      step();
      flush = 1'b1;
      issue(5'd3, 3'd7);
      rs2 = 5'd6;
      rs2_used = 1'b1;
      push("flush", 32'h0, 6'd0, 1'b0);
      step();

      // Used-bit gating on a busy r10, then reset mid-count.
      rs1 = 5'd10;
      rs2 = 5'd10;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      issue(5'd10, 3'd7);
      push("unused_src", 32'h400, 6'd1, 1'b0);
      step();
      rs2_used = 1'b1;
      push("rs2_used", 32'h400, 6'd1, 1'b1);
      compare();
      reset = 1'b1;
      push("mid_reset", 32'h0, 6'd0, 1'b0);
      step();
      reset = 1'b0;
      push("post_reset", 32'h0, 6'd0, 1'b0);
      step();

      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL queue_leftover observed %0d entries required 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
